// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider:
// FSM state encoding and the counter-width helper.
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sub_step.sv
// (W+1)-bit ripple subtractor from full-adder cells: a + ~b + 1.
// no_borrow is the final carry out.
module sub_step #(
  parameter int W = 4
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  output logic [W:0] diff,
  output logic       no_borrow
);

  logic [W:0] bn;
  logic       cy;

  assign bn = ~b;

  always_comb begin
    diff = '0;
    cy   = 1'b1;
    for (int i = 0; i <= W; i++) begin
      diff[i] = a[i] ^ bn[i] ^ cy;
      cy      = (a[i] & bn[i]) | (cy & (a[i] ^ bn[i]));
    end
    no_borrow = cy;
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero short-circuits straight to DONE.
module seq_divider
  import div_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         dbz
);

  localparam int CW = clog2(W + 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    a_q, a_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    a_sh;
  logic [W-1:0]  q_sh;
  logic [W:0]    t;
  logic          nb;

  // {A,Q} shifted left as one register pair
  assign a_sh = (a_q << 1) | {{W{1'b0}}, q_q[W-1]};
  assign q_sh = q_q << 1;

  sub_step #(.W(W)) u_step (
    .a         (a_sh),
    .b         ({1'b0, m_q}),
    .diff      (t),
    .no_borrow (nb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = '0;
          q_d   = dividend;
          m_d   = divisor;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        a_d   = nb ? t : a_sh;
        q_d   = {q_sh[W-1:1], nb};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_DONE;
          quot_d  = q_d;
          rem_d   = a_d[W-1:0];
          dbz_d   = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign quot = quot_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (W=4) against
// plain / and % arithmetic.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         dbz;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.W(W)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .dbz      (dbz)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_q(input int a, input int b);
    return (b == 0) ? {W{1'b1}} : W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input int a, input int b);
    return (b == 0) ? W'(a) : W'(a % b);
  endfunction

  // Issue one op from IDLE; lat = edges after the start edge until done is seen.
  task automatic run_op(input int a, input int b,
                        output int lat, output bit one_wide,
                        output bit busy0);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    busy0    = busy;
    lat      = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    one_wide = (lat >= 0) && !done;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    checks++;
    if ({busy, done, quot, rem, dbz} !== '0) begin
      failures++;
      $display("FAIL reset got=%b%b %h %h %b exp=all zero",
               busy, done, quot, rem, dbz);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; bit w1; bit b0;
    run_op(13, 3, lat, w1, b0);
    checks++;
    if (lat !== W) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=%0d", lat, W);
    end
    checks++;
    if ({quot, rem, dbz} !== {4'd4, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL basic_13_3 got=q%0d r%0d z%0d exp=q4 r1 z0",
               quot, rem, dbz);
    end
    checks++;
    if (!b0 || !w1) begin
      failures++;
      $display("FAIL basic_busy_done got=busy%0d w%0d exp=1 1", b0, w1);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({quot, rem} !== {4'd4, 4'd1}) begin
      failures++;
      $display("FAIL basic_hold got=q%0d r%0d exp=q4 r1", quot, rem);
    end
  endtask

  task automatic test_edges();
    int ta[3] = '{15, 5, 0};
    int tb[3] = '{1, 7, 9};
    int lat; bit w1; bit b0;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], lat, w1, b0);
      checks++;
      if ({quot, rem, dbz} !== {ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i]), 1'b0}
          || lat !== W) begin
        failures++;
        $display("FAIL edge_%0d_%0d got=q%0d r%0d z%0d lat%0d exp=q%0d r%0d z0 lat%0d",
                 ta[i], tb[i], quot, rem, dbz, lat,
                 ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i]), W);
      end
    end
  endtask

  task automatic test_dbz();
    int lat; bit w1; bit b0;
    run_op(9, 0, lat, w1, b0);
    checks++;
    if (lat !== 0 || !w1) begin
      failures++;
      $display("FAIL dbz_latency got=%0d wide_ok=%0d exp=0 1", lat, w1);
    end
    checks++;
    if ({quot, rem, dbz} !== {4'd15, 4'd9, 1'b1}) begin
      failures++;
      $display("FAIL dbz_9_0 got=q%0d r%0d z%0d exp=q15 r9 z1",
               quot, rem, dbz);
    end
    run_op(8, 2, lat, w1, b0);
    checks++;
    if ({quot, rem, dbz} !== {4'd4, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL dbz_clear got=q%0d r%0d z%0d exp=q4 r0 z0",
               quot, rem, dbz);
    end
  endtask

  task automatic test_ignore_start();
    int n_done;
    bit held;
    dividend = 4'd14;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd2;
    @(posedge clk); #1;
    start  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_done !== 1) begin
      failures++;
      $display("FAIL ignore_done_count got=%0d exp=1", n_done);
    end
    checks++;
    if ({quot, rem, dbz} !== {4'd2, 4'd4, 1'b0}) begin
      failures++;
      $display("FAIL ignore_14_5 got=q%0d r%0d z%0d exp=q2 r4 z0",
               quot, rem, dbz);
    end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk); #1;
      if (quot !== 4'd2 || rem !== 4'd4) held = 1'b0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL ignore_hold got=q%0d r%0d exp=q2 r4", quot, rem);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit w1; bit b0;
    int n_done;
    dividend = 4'd11;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    checks++;
    if ({busy, done, quot, rem, dbz} !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%b%b %h %h %b exp=all zero",
               busy, done, quot, rem, dbz);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_b  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_done !== 0) begin
      failures++;
      $display("FAIL mid_no_done got=%0d exp=0", n_done);
    end
    run_op(11, 3, lat, w1, b0);
    checks++;
    if ({quot, rem, dbz} !== {4'd3, 4'd2, 1'b0} || lat !== W) begin
      failures++;
      $display("FAIL mid_after got=q%0d r%0d z%0d lat%0d exp=q3 r2 z0 lat%0d",
               quot, rem, dbz, lat, W);
    end
  endtask

  task automatic test_exhaustive();
    int lat; bit w1; bit b0;
    int exp_lat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, lat, w1, b0);
        exp_lat = (b == 0) ? 0 : W;
        checks++;
        if (quot !== ref_q(a, b) || rem !== ref_r(a, b)
            || dbz !== (b == 0)) begin
          failures++;
          $display("FAIL exh_%0d_%0d got=q%0d r%0d z%0d exp=q%0d r%0d z%0d",
                   a, b, quot, rem, dbz, ref_q(a, b), ref_r(a, b), b == 0);
        end
        checks++;
        if (lat !== exp_lat || !w1 || !b0) begin
          failures++;
          $display("FAIL exh_timing_%0d_%0d got=lat%0d w%0d b%0d exp=lat%0d w1 b1",
                   a, b, lat, w1, b0, exp_lat);
        end
      end
    end
  endtask

  task automatic test_random();
    int lat; bit w1; bit b0;
    int a, b;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      run_op(a, b, lat, w1, b0);
      checks++;
      if (quot !== ref_q(a, b) || rem !== ref_r(a, b)
          || dbz !== (b == 0) || lat < 0) begin
        failures++;
        $display("FAIL rand_%0d_%0d got=q%0d r%0d z%0d lat%0d exp=q%0d r%0d z%0d",
                 a, b, quot, rem, dbz, lat, ref_q(a, b), ref_r(a, b), b == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_dbz();
    test_ignore_start();
    test_reset_mid();
    test_exhaustive();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
